// File: rtl/nibbler_pkg.sv
// Shared types and sizing for the Nibbler output path.
package nibbler_pkg;
    localparam int NIBBLE_W       = 4;
    localparam int OUT_FIFO_DEPTH = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // Occupancy view of the output queue; ACTIVE gates portValid.
    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_ACTIVE = 1'b1
    } fifo_state_t;
endpackage

// File: rtl/nibble_fifo.sv
// Small power-of-two FIFO: storage, wrapping pointers, occupancy count,
// full flag and an EMPTY/ACTIVE state that drives the valid output.
// Push/pop arrive already qualified by the caller.
module nibble_fifo
    import nibbler_pkg::*;
#(
    parameter int DATA_W = NIBBLE_W,
    parameter int DEPTH  = OUT_FIFO_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              valid,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    fifo_state_t       state_q;
    fifo_state_t       state_d;

    // Storage write; contents need no reset since empty reads are masked.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // State register for the EMPTY/ACTIVE view.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave ACTIVE only when the last entry is popped alone.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY:  if (push) state_d = ST_ACTIVE;
            ST_ACTIVE: if (pop && !push && count == CNT_W'(1)) state_d = ST_EMPTY;
            default:   state_d = ST_EMPTY;
        endcase
    end

    assign valid = (state_q == ST_ACTIVE);
    assign full  = (count == CNT_W'(DEPTH));
    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/nibble_out_port.sv
// Output port for the Nibbler accumulator: OUT strobes queue the
// accumulator nibble, and the queue is drained over valid/ready.
module nibble_out_port
    import nibbler_pkg::*;
#(
    parameter int DATA_W = NIBBLE_W,
    parameter int DEPTH  = OUT_FIFO_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] portData,
    output logic              portValid,
    input  logic              portReady,
    output logic              full,
    output logic              overflow,
    output logic [CNT_W-1:0]  count
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    // A pop frees a slot in the same edge, so a full queue still accepts.
    assign pop  = portValid && portReady;
    assign push = enable && (!full || pop);

    nibble_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (dataIn),
        .rdata (head),
        .full  (full),
        .valid (portValid),
        .count (count)
    );

    // Sticky record of any strobe dropped because the queue was full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (enable && !push) begin
            overflow <= 1'b1;
        end
    end

    // Stale storage never reaches the pins while the queue is empty.
    assign portData = portValid ? head : '0;
endmodule
